// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor
//  Purpose  : Bit-serial unsigned subtractor, a - b one bit per clock, LSB
//             first, through a single full-subtractor cell and a registered
//             borrow. Start/done handshake; result held until the next one.
//  Revision : 1.0  initial release
// ============================================================================
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   // Counter only has to reach WIDTH-1; WIDTH >= 2 keeps this at least 1 bit.
   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   sa_q, sa_d;
   logic [WIDTH-1:0]   sb_q, sb_d;
   logic [WIDTH-1:0]   sd_q, sd_d;
   logic               bin_q, bin_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   diff_q, diff_d;
   logic               borrow_q, borrow_d;

   logic               x, y, d_bit, bout;

   // Next-state logic: load on start, one full-subtractor step per RUN edge.
   always_comb begin
      state_d  = state_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      sd_d     = sd_q;
      bin_d    = bin_q;
      cnt_d    = cnt_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;

      x     = sa_q[0];
      y     = sb_q[0];
      d_bit = x ^ y ^ bin_q;
      bout  = (~x & y) | (~(x ^ y) & bin_q);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               sa_d    = a;
               sb_d    = b;
               bin_d   = 1'b0;
               cnt_d   = '0;
               sd_d    = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            sd_d  = {d_bit, sd_q[WIDTH-1:1]};
            sa_d  = sa_q >> 1;
            sb_d  = sb_q >> 1;
            bin_d = bout;
            cnt_d = cnt_q + CNT_W'(1);
            // Last bit: publish the fully assembled word and the MSB borrow.
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               diff_d   = {d_bit, sd_q[WIDTH-1:1]};
               borrow_d = bout;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset clears everything asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         sa_q     <= '0;
         sb_q     <= '0;
         sd_q     <= '0;
         bin_q    <= 1'b0;
         cnt_q    <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         sd_q     <= sd_d;
         bin_q    <= bin_d;
         cnt_q    <= cnt_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
      end
   end

   assign busy   = (state_q != S_IDLE);
   assign done   = (state_q == S_DONE);
   assign diff   = diff_q;
   assign borrow = borrow_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_subtractor
//  Purpose  : Scoreboard bench for serial_subtractor (WIDTH = 8). Stimulus
//             pushes expected results computed with plain arithmetic; a
//             monitor pops and compares on every done pulse.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_subtractor;

   localparam int WIDTH = 8;

   logic             clk;
   logic             reset;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow;

   typedef struct {
      logic [WIDTH-1:0] d;
      logic             bo;
      int               cyc;
   } exp_t;

   exp_t             sb[$];
   int               vectors    = 0;
   int               miscompares = 0;
   int               cyc        = 0;
   int               busy_len   = 0;
   logic [WIDTH-1:0] prev_d     = '0;
   logic             prev_bo    = 1'b0;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .borrow (borrow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge counter used to time-stamp accepted starts and done pulses.
   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      vectors = vectors + 1;
      if (act != exp) begin
         miscompares = miscompares + 1;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference: unsigned subtraction modulo 2^WIDTH, borrow when a < b.
   function automatic exp_t model(input int av, input int bv, input int dcyc);
      exp_t e;
      e.d   = WIDTH'((av - bv + (1 << WIDTH)) % (1 << WIDTH));
      e.bo  = (av < bv);
      e.cyc = dcyc;
      return e;
   endfunction

   // Monitor: busy run length and result checks on each done pulse.
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         busy_len = 0;
      end else begin
         if (busy) busy_len = busy_len + 1;
         else if (busy_len != 0) begin
            chk("busy_len", busy_len, WIDTH + 1);
            busy_len = 0;
         end
         if (done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("diff", int'(diff), int'(e.d));
               chk("borrow", int'(borrow), int'(e.bo));
               chk("done_cycle", cyc, e.cyc);
               prev_d  = e.d;
               prev_bo = e.bo;
            end
         end
      end
   end

   task automatic wait_to(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if (sb.size() == 0) break;
      end
      chk("drain_timeout", sb.size(), 0);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      chk("idle_before_start", int'(busy), 0);
   endtask

   // One operation from IDLE; checks the old result is held mid-RUN.
   task automatic run_op(input int av, input int bv, output int acc);
      wait_idle();
      a     = WIDTH'(av);
      b     = WIDTH'(bv);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      acc   = cyc;
      sb.push_back(model(av, bv, acc + WIDTH));
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      wait_to(acc + 4);
      @(negedge clk);
      chk("busy_in_run", int'(busy), 1);
      chk("diff_held", int'(diff), int'(prev_d));
      chk("borrow_held", int'(borrow), int'(prev_bo));
   endtask

   initial begin
      int acc;
      int tgt;
      reset = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      #1 reset = 1'b1;
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_diff", int'(diff), 0);
      chk("rst_borrow", int'(borrow), 0);
      #1 reset = 1'b0;
      #1;
      chk("rel_busy", int'(busy), 0);
      chk("rel_diff", int'(diff), 0);

      // Directed cases.
      run_op(200, 55, acc);  drain(20);
      run_op(5, 10, acc);    drain(20);
      run_op(0, 1, acc);     drain(20);
      run_op(0, 0, acc);     drain(20);
      run_op(77, 77, acc);   drain(20);
      run_op(255, 0, acc);   drain(20);
      run_op(0, 255, acc);   drain(20);

      // Starts during RUN and DONE are ignored.
      run_op(100, 1, acc);
      a = 8'd3; b = 8'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_to(acc + WIDTH);
      @(negedge clk);
      chk("done_state", int'(done), 1);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      drain(20);
      repeat (3) @(negedge clk);
      chk("no_queued_start", int'(busy), 0);

      // start held high: accepts every WIDTH+2 edges.
      @(negedge clk);
      a = WIDTH'($urandom); b = WIDTH'($urandom); start = 1'b1;
      tgt = cyc + 1;
      for (int k = 0; k < 3; k++) begin
         wait_to(tgt);
         sb.push_back(model(int'(a), int'(b), tgt + WIDTH));
         a = WIDTH'($urandom);
         b = WIDTH'($urandom);
         tgt = tgt + WIDTH + 2;
      end
      start = 1'b0;
      drain(40);

      // Reset mid-operation: aborted, outputs cleared, no done.
      wait_idle();
      a = 8'd250; b = 8'd3; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      acc = cyc;
      wait_to(acc + 4);
      #2 reset = 1'b1;
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_diff", int'(diff), 0);
      chk("abort_borrow", int'(borrow), 0);
      prev_d  = '0;
      prev_bo = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      run_op(9, 4, acc); drain(20);

      // Random operands.
      for (int i = 0; i < 12; i++) begin
         int av, bv;
         av = int'($urandom_range(0, 255));
         bv = (i % 4 == 0) ? av : int'($urandom_range(0, 255));
         run_op(av, bv, acc);
         drain(20);
      end

      repeat (4) @(negedge clk);
      chk("final_queue", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
